mux_3to1: RTL and testbench



---
 rtl/mux_pkg.sv | 9 +
 rtl/mux_out_reg.sv | 19 +
 rtl/mux_3to1.sv | 63 ++++++
 tb/tb_mux_3to1.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Select-code constants and select type shared by the 3:1 mux and its users.
package mux_pkg;
  typedef logic [1:0] sel_t;

  localparam sel_t SEL_DEF = 2'b00;
  localparam sel_t SEL_01  = 2'b01;
  localparam sel_t SEL_10  = 2'b10;
  localparam sel_t SEL_11  = 2'b11;
endpackage

// File: rtl/mux_out_reg.sv
// WIDTH-wide flop with synchronous active-high reset to RESET_VAL; no enable.
module mux_out_reg #(
  parameter int unsigned          WIDTH     = 32,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) data_q <= RESET_VAL;
    else         data_q <= i_d;
  end

  assign o_q = data_q;
endmodule

// File: rtl/mux_3to1.sv
// 3:1 select mux with zero default, plus a one-cycle registered copy.
// Optional MUX3TO1_SEL_ERR_EN adds a registered flag for the unused select code.
module mux_3to1
  import mux_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  sel_t             i_sel,
  input  logic [WIDTH-1:0] i_data_01,
  input  logic [WIDTH-1:0] i_data_10,
  input  logic [WIDTH-1:0] i_data_11,
  output logic [WIDTH-1:0] o_data,
`ifdef MUX3TO1_SEL_ERR_EN
  output logic             o_sel_err,
`endif
  output logic [WIDTH-1:0] o_data_q
);
  // Unknown select bits match no item and fall to the zero default.
  always_comb begin
    o_data = '0;
    case (i_sel)
      SEL_01:  o_data = i_data_01;
      SEL_10:  o_data = i_data_10;
      SEL_11:  o_data = i_data_11;
      default: o_data = '0;
    endcase
  end

  mux_out_reg #(
    .WIDTH    (WIDTH),
    .RESET_VAL(RESET_VAL)
  ) u_data_reg (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_d    (o_data),
    .o_q    (o_data_q)
  );

`ifdef MUX3TO1_SEL_ERR_EN
  logic sel_err_d;

  always_comb begin
    sel_err_d = 1'b0;
    case (i_sel)
      SEL_DEF: sel_err_d = 1'b1;
      default: sel_err_d = 1'b0;
    endcase
  end

  mux_out_reg #(
    .WIDTH    (1),
    .RESET_VAL(1'b0)
  ) u_err_reg (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_d    (sel_err_d),
    .o_q    (o_sel_err)
  );
`endif
endmodule

// File: tb/tb_mux_3to1.sv
// Self-checking bench for mux_3to1: directed literal checks plus randomized
// stimulus compared every cycle against a table-lookup reference model.
module tb_mux_3to1;
  localparam int W = 32;
  localparam logic [W-1:0] RST_V = '0;

  logic         i_clk = 1'b0;
  logic         i_reset;
  logic [1:0]   i_sel;
  logic [W-1:0] i_data_01, i_data_10, i_data_11;
  logic [W-1:0] o_data, o_data_q;
`ifdef MUX3TO1_SEL_ERR_EN
  logic         o_sel_err;
`endif

  int total_cnt = 0;
  int pass_cnt  = 0;
  bit chk_en    = 1'b0;
  logic [W-1:0] exp_q;
  logic         exp_err;

  mux_3to1 #(.WIDTH(W), .RESET_VAL(RST_V)) dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_sel    (i_sel),
    .i_data_01(i_data_01),
    .i_data_10(i_data_10),
    .i_data_11(i_data_11),
    .o_data   (o_data),
`ifdef MUX3TO1_SEL_ERR_EN
    .o_sel_err(o_sel_err),
`endif
    .o_data_q (o_data_q)
  );

  always #5 i_clk = ~i_clk;

  // Reference: index a source table by the select code; slot 0 is the default.
  function automatic logic [W-1:0] model(logic [1:0] s, logic [W-1:0] a,
                                         logic [W-1:0] b, logic [W-1:0] c);
    logic [W-1:0] src [4];
    if ($isunknown(s)) return '0;
    src[0] = '0; src[1] = a; src[2] = b; src[3] = c;
    return src[s];
  endfunction

  task automatic check(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else pass_cnt++;
  endtask

  task automatic step();
    @(posedge i_clk);
    #2;
  endtask

  // Expected registered outputs, advanced at each rising edge.
  always @(posedge i_clk) begin
    exp_q   = i_reset ? RST_V : model(i_sel, i_data_01, i_data_10, i_data_11);
    exp_err = i_reset ? 1'b0 : (i_sel === 2'b00);
  end

  always @(negedge i_clk) begin
    if (chk_en) begin
      check("cyc_o_data", o_data, model(i_sel, i_data_01, i_data_10, i_data_11));
      check("cyc_o_data_q", o_data_q, exp_q);
`ifdef MUX3TO1_SEL_ERR_EN
      check("cyc_o_sel_err", W'(o_sel_err), W'(exp_err));
`endif
    end
  end

  initial begin
    i_reset = 1'b1; i_sel = 2'b00;
    i_data_01 = '0; i_data_10 = '0; i_data_11 = '0;
    step(); step();
    chk_en = 1'b1;
    check("reset_q", o_data_q, 32'h0000_0000);
`ifdef MUX3TO1_SEL_ERR_EN
    check("reset_err", W'(o_sel_err), 32'h0);
`endif

    i_reset = 1'b0; i_sel = 2'b01;
    i_data_01 = 32'h1; i_data_10 = 32'h2; i_data_11 = 32'h3;
    #1 check("sel01_comb", o_data, 32'h0000_0001);
    step();
    check("sel01_q", o_data_q, 32'h0000_0001);
    i_sel = 2'b10;
    #1 check("sel10_comb", o_data, 32'h0000_0002);
    i_sel = 2'b11;
    #1 check("sel11_comb", o_data, 32'h0000_0003);
    i_sel = 2'b00;
    #1 check("sel00_comb", o_data, 32'h0000_0000);
    step();
    check("sel00_q", o_data_q, 32'h0000_0000);
`ifdef MUX3TO1_SEL_ERR_EN
    check("sel00_err", W'(o_sel_err), 32'h1);
`endif

    i_sel = 2'b11;
    step();
    check("pre_rst_q", o_data_q, 32'h0000_0003);
    i_reset = 1'b1;
    step();
    check("mid_rst_q", o_data_q, 32'h0000_0000);
    check("mid_rst_comb", o_data, 32'h0000_0003);
    i_reset = 1'b0;
    step();
    check("post_rst_q", o_data_q, 32'h0000_0003);

    i_sel = 2'b10;
    step();
    check("hold_q_before", o_data_q, 32'h0000_0002);
    i_data_10 = 32'hDEAD_BEEF;
    #1 check("midcyc_comb", o_data, 32'hDEAD_BEEF);
    check("midcyc_q_hold", o_data_q, 32'h0000_0002);
    step();
    check("midcyc_q_next", o_data_q, 32'hDEAD_BEEF);

    i_sel = 2'bxx;
    #1 check("xsel_comb", o_data, model(i_sel, i_data_01, i_data_10, i_data_11));
    check("xsel_no_x", W'($isunknown(o_data)), 32'h0);
    step();
    check("xsel_q_no_x", W'($isunknown(o_data_q)), 32'h0);

    for (int n = 0; n < 400; n++) begin
      step();
      i_reset   = ($urandom_range(0, 15) == 0);
      i_sel     = 2'($urandom_range(0, 3));
      i_data_01 = $urandom;
      i_data_10 = $urandom;
      i_data_11 = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        #1 i_data_01 = $urandom;
        i_data_11 = $urandom;
      end
    end
    step(); step();
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
